// File: rtl/mult_fu_pipe.sv
// Pipelined integer multiply unit: NUM_STAGES elastic stages, each consuming XLEN/NUM_STAGES bits of opb.
// Optional one-cycle-early wakeup tag is enabled by defining MULT_EARLY_TAG_EN.
module mult_fu_pipe #(
  parameter int NUM_STAGES = 4,
  parameter int XLEN       = 64,
  parameter int TAG_W      = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [XLEN-1:0]  issue_opa,
  input  logic [XLEN-1:0]  issue_opb,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  input  logic             squash,
  input  logic             cdb_grant,
  output logic             done_valid,
  output logic [XLEN-1:0]  done_result,
  output logic [TAG_W-1:0] done_tag,
  output logic             early_tag_valid,
  output logic [TAG_W-1:0] early_tag
);

  localparam int S = NUM_STAGES;
  localparam int C = XLEN / NUM_STAGES;

  logic             valid_q [S];
  logic [TAG_W-1:0] tag_q   [S];
  logic [XLEN-1:0]  opa_q   [S];
  logic [XLEN-1:0]  opb_q   [S];
  logic [XLEN-1:0]  acc_q   [S];

  logic             valid_d [S];
  logic [TAG_W-1:0] tag_d   [S];
  logic [XLEN-1:0]  opa_d   [S];
  logic [XLEN-1:0]  opb_d   [S];
  logic [XLEN-1:0]  acc_d   [S];

  logic [S-1:0] adv;
  logic         grant_eff;

  // The CDB is flushed along with us on squash, so a grant then means nothing.
  assign grant_eff = cdb_grant & ~squash;

  // A stage may advance if any stage at or after it is empty, or the head is granted.
  always_comb begin : adv_chain
    logic run;
    run = grant_eff;
    adv = '0;
    for (int k = S - 1; k >= 0; k--) begin
      run    = run | ~valid_q[k];
      adv[k] = run;
    end
  end

  always_comb begin
    valid_d[0] = issue_valid;
    tag_d[0]   = issue_tag;
    opa_d[0]   = issue_opa;
    opb_d[0]   = issue_opb;
    acc_d[0]   = issue_opa * XLEN'(issue_opb[C-1:0]);
    for (int k = 1; k < S; k++) begin
      valid_d[k] = valid_q[k-1];
      tag_d[k]   = tag_q[k-1];
      opa_d[k]   = opa_q[k-1];
      opb_d[k]   = opb_q[k-1];
      acc_d[k]   = acc_q[k-1]
                 + ((opa_q[k-1] * XLEN'(opb_q[k-1][k*C +: C])) << (k*C));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        acc_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (adv[k]) begin
          tag_q[k] <= tag_d[k];
          opa_q[k] <= opa_d[k];
          opb_q[k] <= opb_d[k];
          acc_q[k] <= acc_d[k];
        end
        if (squash)
          valid_q[k] <= 1'b0;
        else if (adv[k])
          valid_q[k] <= valid_d[k];
      end
    end
  end

  assign issue_ready = adv[0];
  assign done_valid  = valid_q[S-1];
  assign done_result = acc_q[S-1];
  assign done_tag    = tag_q[S-1];

`ifdef MULT_EARLY_TAG_EN
  assign early_tag_valid = valid_q[S-2] & adv[S-2] & ~squash & ~reset;
  assign early_tag       = tag_q[S-2];
`else
  assign early_tag_valid = 1'b0;
  assign early_tag       = '0;
`endif

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Self-checking bench for mult_fu_pipe: directed vector table, backpressure drain, and
// randomized traffic checked against a queue-based model of the elastic pipeline.
module tb_mult_fu_pipe;
  localparam int S = 4;
`ifdef MULT_EARLY_TAG_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, issue_valid, squash, cdb_grant;
  logic [63:0] issue_opa, issue_opb;
  logic [6:0]  issue_tag;
  logic        issue_ready, done_valid, early_tag_valid;
  logic [63:0] done_result;
  logic [6:0]  done_tag, early_tag;

  mult_fu_pipe dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_opa(issue_opa), .issue_opb(issue_opb),
    .issue_tag(issue_tag), .issue_ready(issue_ready),
    .squash(squash), .cdb_grant(cdb_grant),
    .done_valid(done_valid), .done_result(done_result), .done_tag(done_tag),
    .early_tag_valid(early_tag_valid), .early_tag(early_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic iv; logic [63:0] a, b; logic [6:0] tg; logic gr, sq, rs;
    logic chk, full, edv; logic [63:0] eres; logic [6:0] etag;
    logic erdy, eev; logic [6:0] eet;
  } vec_t;

  typedef struct { logic [6:0] tag; logic [63:0] res; int acc; } op_t;

  vec_t tbl[$];
  op_t  mq[$];
  int   last_dep = -100;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  logic last_ready;
  logic m_dv, m_rdy, m_ev;
  logic [6:0] m_et;

  function automatic vec_t mk(input logic iv, input logic [63:0] a, input logic [63:0] b,
                              input logic [6:0] tg, input logic gr, input logic sq, input logic rs);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.tg = tg; v.gr = gr; v.sq = sq; v.rs = rs;
    v.chk = 0; v.full = 0; v.edv = 0; v.eres = '0; v.etag = '0; v.erdy = 0; v.eev = 0; v.eet = '0;
    return v;
  endfunction

  function automatic void tx(input vec_t vin, input logic full, input logic edv, input logic [63:0] eres,
                             input logic [6:0] etag, input logic erdy, input logic eev, input logic [6:0] eet);
    vec_t v;
    v = vin;
    v.chk = 1; v.full = full; v.edv = edv; v.eres = eres; v.etag = etag;
    v.erdy = erdy; v.eev = eev; v.eet = eet;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_eval();
    int  harr;
    logic g;
    g     = cdb_grant && !squash;
    m_rdy = (mq.size() < S) || g;
    m_dv  = 1'b0; m_ev = 1'b0; m_et = '0; harr = 0;
    if (mq.size() > 0) begin
      harr = (mq[0].acc + S > last_dep + 1) ? mq[0].acc + S : last_dep + 1;
      m_dv = (cyc >= harr);
    end
    if (EARLY && !squash && !reset) begin
      if (mq.size() > 0 && !m_dv && harr == cyc + 1) begin
        m_ev = 1'b1; m_et = mq[0].tag;
      end else if (m_dv && g && mq.size() > 1 && mq[1].acc + S <= cyc + 1) begin
        m_ev = 1'b1; m_et = mq[1].tag;
      end
    end
  endtask

  task automatic model_update();
    op_t o;
    if (reset || squash) begin
      mq.delete();
    end else begin
      if (m_dv && cdb_grant) begin
        void'(mq.pop_front());
        last_dep = cyc;
      end
      if (issue_valid && m_rdy) begin
        o.tag = issue_tag; o.res = issue_opa * issue_opb; o.acc = cyc;
        mq.push_back(o);
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clock);
    issue_valid = v.iv; issue_opa = v.a; issue_opb = v.b; issue_tag = v.tg;
    cdb_grant = v.gr; squash = v.sq; reset = v.rs;
    #1;
    model_eval();
    if (cyc > 0) begin
      chk("model_done_valid", done_valid, m_dv);
      chk("model_issue_ready", issue_ready, m_rdy);
      chk("model_early_valid", early_tag_valid, m_ev);
      if (m_dv) begin
        chk("model_done_result", done_result, mq[0].res);
        chk("model_done_tag", done_tag, mq[0].tag);
      end
      if (m_ev) chk("model_early_tag", early_tag, m_et);
      if (!EARLY) chk("model_early_tag_tied", early_tag, 0);
    end
    if (v.chk) begin
      chk("tbl_done_valid", done_valid, v.edv);
      chk("tbl_issue_ready", issue_ready, v.erdy);
      chk("tbl_early_valid", early_tag_valid, v.eev);
      if (v.edv || v.full) begin
        chk("tbl_done_result", done_result, v.eres);
        chk("tbl_done_tag", done_tag, v.etag);
      end
      if (v.eev || v.full) chk("tbl_early_tag", early_tag, v.eet);
    end
    model_update();
    last_ready = issue_ready;
    cyc++;
  endtask

  initial begin
    vec_t v, idle;
    int   n;
    logic [6:0] got[$];

    reset = 1; issue_valid = 0; issue_opa = 0; issue_opb = 0; issue_tag = 0;
    cdb_grant = 0; squash = 0;
    idle = mk(0, 0, 0, 0, 1, 0, 0);

    // reset held two cycles with an issue pending
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1));
    tx(mk(1, 1, 1, 1, 0, 0, 1), 1, 0, 0, 0, 1, 0, 0);
    tx(idle, 1, 0, 0, 0, 1, 0, 0);
    // single op 3*7 tag 3 issued at row 3, done at row 7
    tx(mk(1, 3, 7, 3, 1, 0, 0), 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, EARLY, 3);
    tx(idle, 0, 1, 21, 3, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    // tag 5 at row 9: early hint row 12, done row 13
    tx(mk(1, 2, 5, 5, 1, 0, 0), 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, EARLY, 5);
    tx(idle, 0, 1, 10, 5, 1, 0, 0);
    // back-to-back all-ones * 2
    for (int i = 0; i < 4; i++)
      tx(mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 7'(i + 1), 1, 0, 0), 0, 0, 0, 0, 1,
         (i == 3) ? EARLY : 1'b0, 1);
    for (int i = 0; i < 4; i++)
      tx(idle, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 7'(i + 1), 1, (i < 3) ? EARLY : 1'b0, 7'(i + 2));
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    // squash with three in flight plus a same-cycle issue
    for (int i = 0; i < 3; i++)
      tx(mk(1, 64'(i + 2), 64'(i + 3), 7'(20 + i), 1, 0, 0), 0, 0, 0, 0, 1, 0, 0);
    tx(mk(1, 9, 9, 23, 1, 1, 0), 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(mk(1, 6, 7, 9, 1, 0, 0), 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, EARLY, 9);
    tx(idle, 0, 1, 42, 9, 1, 0, 0);
    tx(idle, 0, 0, 0, 0, 1, 0, 0);

    foreach (tbl[i]) step(tbl[i]);

    // backpressure: six ops offered with grant low, then drained
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(mk(n < 6, 64'(100 + n), 3, 7'(10 + n), 0, 0, 0));
      if (last_ready && n < 6) n++;
    end
    chk("bp_accepts", 64'(n), 4);
    chk("bp_ready_full", issue_ready, 0);
    chk("bp_head_valid", done_valid, 1);
    chk("bp_head_tag", done_tag, 10);
    chk("bp_head_result", done_result, 300);
    for (int i = 0; i < 16; i++) begin
      step(mk(n < 6, 64'(100 + n), 3, 7'(10 + n), 1, 0, 0));
      if (done_valid && cdb_grant) got.push_back(done_tag);
      if (last_ready && n < 6) n++;
    end
    chk("bp_drain_count", 64'(got.size()), 6);
    foreach (got[i]) chk("bp_drain_order", got[i], 7'(10 + i));

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      v = mk($urandom_range(0, 9) < 7,
             ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom},
             7'($urandom), $urandom_range(0, 9) < 6,
             $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2);
      step(v);
    end
    for (int i = 0; i < 10; i++) step(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
